// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and default widths for pong_drain
// Optional checksum build: PONG_DRAIN_CHECKSUM_EN adds the SUM state.
package pong_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SEQ_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
`ifdef PONG_DRAIN_CHECKSUM_EN
        SUM,
`endif
        DONE
    } state_e;

endpackage

// File: rtl/pong_drain.sv
// rtl/pong_drain.sv - drains a counted burst from an upstream FIFO to a tagged output
// Optional checksum word after the burst: PONG_DRAIN_CHECKSUM_EN.
module pong_drain
    import pong_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start__ENA,
    input  logic [CNT_WIDTH-1:0]  start_count,
    output logic                  start__RDY,
    input  logic [DATA_WIDTH-1:0] in_first,
    input  logic                  in_first__RDY,
    input  logic                  in_deq__RDY,
    output logic                  in_deq__ENA,
    output logic                  out_heard__ENA,
    output logic [DATA_WIDTH-1:0] out_heard_v,
    output logic [SEQ_WIDTH-1:0]  out_heard_seq,
    input  logic                  out_heard__RDY,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
`ifdef PONG_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        seq_d          = seq_q;
        remaining_d    = remaining_q;
`ifdef PONG_DRAIN_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        start__RDY     = 1'b0;
        in_deq__ENA    = 1'b0;
        out_heard__ENA = 1'b0;
        out_heard_v    = '0;
        out_heard_seq  = '0;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                start__RDY = 1'b1;
                if (start__ENA) begin
                    remaining_d = start_count;
`ifdef PONG_DRAIN_CHECKSUM_EN
                    sum_d       = '0;
`endif
                    state_d     = (start_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (in_first__RDY && in_deq__RDY) begin
                    in_deq__ENA = 1'b1;
                    hold_d      = in_first;
`ifdef PONG_DRAIN_CHECKSUM_EN
                    sum_d       = sum_q + in_first;
`endif
                    state_d     = SEND;
                end
            end
            SEND: begin
                out_heard__ENA = 1'b1;
                out_heard_v    = hold_q;
                out_heard_seq  = seq_q;
                if (out_heard__RDY) begin
                    seq_d       = seq_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    // remaining_q is the pre-decrement count, so 1 means last word
                    if (remaining_q != CNT_WIDTH'(1)) begin
                        state_d = FETCH;
                    end else begin
`ifdef PONG_DRAIN_CHECKSUM_EN
                        state_d = SUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef PONG_DRAIN_CHECKSUM_EN
            SUM: begin
                out_heard__ENA = 1'b1;
                out_heard_v    = sum_q;
                out_heard_seq  = seq_q;
                if (out_heard__RDY) begin
                    seq_d   = seq_q + 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            seq_q       <= '0;
            remaining_q <= '0;
`ifdef PONG_DRAIN_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            seq_q       <= seq_d;
            remaining_q <= remaining_d;
`ifdef PONG_DRAIN_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_pong_drain.sv
// tb/tb_pong_drain.sv - directed self-checking bench for pong_drain
// Honours PONG_DRAIN_CHECKSUM_EN when the build defines it.
module tb_pong_drain;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int CW = 8;
`ifdef PONG_DRAIN_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          CLK = 1'b0;
    logic          nRST;
    logic          start__ENA;
    logic [CW-1:0] start_count;
    logic          start__RDY;
    logic [DW-1:0] in_first;
    logic          in_first__RDY;
    logic          in_deq__RDY;
    logic          in_deq__ENA;
    logic          out_heard__ENA;
    logic [DW-1:0] out_heard_v;
    logic [SW-1:0] out_heard_seq;
    logic          out_heard__RDY;
    logic          done;

    always #5 CLK = ~CLK;

    // SEQ_WIDTH is narrowed so the wrap-around fits in a short run
    pong_drain #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(start__ENA), .start_count(start_count), .start__RDY(start__RDY),
        .in_first(in_first), .in_first__RDY(in_first__RDY),
        .in_deq__RDY(in_deq__RDY), .in_deq__ENA(in_deq__ENA),
        .out_heard__ENA(out_heard__ENA), .out_heard_v(out_heard_v),
        .out_heard_seq(out_heard_seq), .out_heard__RDY(out_heard__RDY),
        .done(done)
    );

    logic [DW-1:0] words [0:511];
    logic [8:0]    idx;
    logic [9:0]    nwords;
    logic          up_en;

    assign in_first      = words[idx];
    assign in_first__RDY = up_en && ({1'b0, idx} < nwords);

    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            start_c = 0;
    int            exp_seq = 0;
    int            deq_c[$];
    int            x_c[$];
    int            done_c[$];
    logic [31:0]   x_v[$];
    logic [31:0]   x_s[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        logic pop;
        #2;
        check("deq_guard", 32'(in_deq__ENA && !(in_deq__RDY && in_first__RDY && !out_heard__ENA)), 32'd0);
        if (in_deq__ENA) deq_c.push_back(cyc);
        if (out_heard__ENA && out_heard__RDY) begin
            x_c.push_back(cyc);
            x_v.push_back(out_heard_v);
            x_s.push_back(32'(out_heard_seq));
        end
        if (done) done_c.push_back(cyc);
        pop = in_deq__ENA;
        @(posedge CLK);
        #1;
        if (pop) idx = idx + 9'd1;
        cyc++;
    endtask

    task automatic clear_logs();
        deq_c.delete();
        x_c.delete();
        x_v.delete();
        x_s.delete();
        done_c.delete();
        idx = '0;
    endtask

    task automatic start_burst(input int cnt);
        start_count = CW'(cnt);
        start__ENA  = 1'b1;
        start_c     = cyc;
        step();
        start__ENA  = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while (done_c.size() == 0 && k < budget) begin
            step();
            k++;
        end
        check("done_seen", 32'(done_c.size()), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        nRST = 1'b0; start__ENA = 1'b0; start_count = '0;
        up_en = 1'b1; in_deq__RDY = 1'b1; out_heard__RDY = 1'b1;
        idx = '0; nwords = '0;
        for (int i = 0; i < 512; i++) words[i] = 32'h1000 + 32'(i);

        @(posedge CLK);
        #1;
        step();
        step();
        nRST = 1'b1;
        #1;
        check("rst_start_rdy", 32'(start__RDY), 32'd1);
        check("rst_deq", 32'(in_deq__ENA), 32'd0);
        check("rst_out_en", 32'(out_heard__ENA), 32'd0);
        check("rst_out_v", out_heard_v, 32'd0);
        check("rst_out_seq", 32'(out_heard_seq), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // three words, everything ready
        clear_logs();
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; nwords = 10'd3;
        start_burst(3);
        run_done(40);
        check("b3_deq_cnt", 32'(deq_c.size()), 32'd3);
        check("b3_x_cnt", 32'(x_c.size()), 32'(3 + CS));
        for (int i = 0; i < 3; i++) begin
            check("b3_deq_cyc", 32'(deq_c[i] - start_c), 32'(1 + 2 * i));
            check("b3_x_cyc", 32'(x_c[i] - start_c), 32'(2 + 2 * i));
            check("b3_x_v", x_v[i], 32'h11 * 32'(i + 1));
            check("b3_x_seq", x_s[i], 32'((exp_seq + i) & 255));
        end
        if (CS == 1) begin
            check("b3_sum_v", x_v[3], 32'h66);
            check("b3_sum_seq", x_s[3], 32'((exp_seq + 3) & 255));
        end
        check("b3_done_cyc", 32'(done_c[0] - start_c), 32'(7 + CS));
        exp_seq = (exp_seq + 3 + CS) & 255;

        // downstream stalls five cycles on the first word
        clear_logs();
        words[0] = 32'hA5; words[1] = 32'hB6; nwords = 10'd2;
        out_heard__RDY = 1'b0;
        start_burst(2);
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_v", out_heard_v, 32'hA5);
            check("stall_en", 32'(out_heard__ENA), 32'd1);
            step();
        end
        check("stall_deq_cnt", 32'(deq_c.size()), 32'd1);
        check("stall_x_cnt", 32'(x_c.size()), 32'd0);
        out_heard__RDY = 1'b1;
        run_done(40);
        check("stall_x_cyc", 32'(x_c[0] - start_c), 32'd7);
        check("stall_x_v0", x_v[0], 32'hA5);
        check("stall_x_seq0", x_s[0], 32'(exp_seq));
        check("stall_x_v1", x_v[1], 32'hB6);
        exp_seq = (exp_seq + 2 + CS) & 255;

        // zero-count burst
        clear_logs();
        start_burst(0);
        run_done(10);
        check("z_deq_cnt", 32'(deq_c.size()), 32'd0);
        check("z_x_cnt", 32'(x_c.size()), 32'd0);
        check("z_done_cyc", 32'(done_c[0] - start_c), 32'd1);

        // upstream empty for four FETCH cycles; stray start ignored
        clear_logs();
        words[0] = 32'hC1; words[1] = 32'hC2; nwords = 10'd2;
        up_en = 1'b0;
        start_burst(2);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                start__ENA = 1'b1;
                start_count = 8'd7;
            end
            step();
            start__ENA = 1'b0;
        end
        check("fe_deq_none", 32'(deq_c.size()), 32'd0);
        up_en = 1'b1;
        run_done(40);
        check("fe_deq_cyc", 32'(deq_c[0] - start_c), 32'd5);
        check("fe_deq_cnt", 32'(deq_c.size()), 32'd2);
        check("fe_x_cnt", 32'(x_c.size()), 32'(2 + CS));
        check("fe_x_v0", x_v[0], 32'hC1);
        check("fe_x_v1", x_v[1], 32'hC2);
        check("fe_done_cyc", 32'(done_c[0] - start_c), 32'(9 + CS));
        exp_seq = (exp_seq + 2 + CS) & 255;

        // all-ones count
        clear_logs();
        for (int i = 0; i < 255; i++) words[i] = 32'(i * 3 + 7);
        nwords = 10'd255;
        start_burst(255);
        run_done(700);
        check("max_deq_cnt", 32'(deq_c.size()), 32'd255);
        check("max_x_cnt", 32'(x_c.size()), 32'(255 + CS));
        check("max_last_v", x_v[254], 32'(254 * 3 + 7));
        check("max_last_seq", x_s[254], 32'((exp_seq + 254) & 255));
        exp_seq = (exp_seq + 255 + CS) & 255;

        // walk seq up to all-ones, then cross the wrap
        while (exp_seq != 255) begin
            n = ((255 - exp_seq) & 255) - CS;
            if (n < 1) n = 1;
            clear_logs();
            nwords = 10'(n);
            start_burst(n);
            run_done(600);
            exp_seq = (exp_seq + n + CS) & 255;
        end
        clear_logs();
        words[0] = 32'hDEAD0001; words[1] = 32'hDEAD0002; nwords = 10'd2;
        start_burst(2);
        run_done(20);
        check("wrap_seq0", x_s[0], 32'hFF);
        check("wrap_seq1", x_s[1], 32'h00);
        check("wrap_v1", x_v[1], 32'hDEAD0002);

        // reset during SEND of word 2 of 4
        clear_logs();
        for (int i = 0; i < 4; i++) words[i] = 32'h50 + 32'(i);
        nwords = 10'd4;
        start_burst(4);
        step();
        step();
        step();
        #1;
        check("mid_send_en", 32'(out_heard__ENA), 32'd1);
        check("mid_send_v", out_heard_v, 32'h51);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        #1;
        check("mr_start_rdy", 32'(start__RDY), 32'd1);
        check("mr_deq", 32'(in_deq__ENA), 32'd0);
        check("mr_out_en", 32'(out_heard__ENA), 32'd0);
        check("mr_out_v", out_heard_v, 32'd0);
        check("mr_out_seq", 32'(out_heard_seq), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        step();
        step();
        step();
        check("mr_no_done", 32'(done_c.size()), 32'd0);
        check("mr_no_deq", 32'(deq_c.size()), 32'd2);
        clear_logs();
        words[0] = 32'h77; nwords = 10'd1;
        start_burst(1);
        run_done(20);
        check("mr_after_seq", x_s[0], 32'd0);
        check("mr_after_v", x_v[0], 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
